// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, sync bundle type and helpers
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_PIPE_DLY = 2;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
  } vga_sync_t;

  localparam vga_sync_t SYNC_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

  // en lets a zero-width pulse collapse to "never" without an underflowed hi bound
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] lo,
                                   input logic [9:0] hi, input logic en);
    return en && (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - clock-enabled shift register that aligns sync/blank with mapper RGB
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{vga_clk, reset_n, ce};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (ce) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, frame counter and delayed sync/blank generation
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIPE_DLY = VGA_PIPE_DLY
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_cfg_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must lie in 1..1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       HS_EN  = (H_SYNC != 0);
  localparam logic       VS_EN  = (V_SYNC != 0);

  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [15:0] frames;
  vga_sync_t   raw;
  vga_sync_t   dly;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      draw_x <= '0;
      draw_y <= '0;
      frames <= '0;
    end else if (pix_ce) begin
      if (draw_x == H_LAST) begin
        draw_x <= '0;
        if (draw_y == V_LAST) begin
          draw_y <= '0;
          frames <= frames + 16'd1;
        end else begin
          draw_y <= draw_y + 10'd1;
        end
      end else begin
        draw_x <= draw_x + 10'd1;
      end
    end
  end

  // Gating with reset_n keeps outputs idle in reset even when the delay line is bypassed
  always_comb begin
    raw = SYNC_IDLE;
    if (reset_n) begin
      raw.active = (draw_x < H_ACT) && (draw_y < V_ACT);
      raw.hs_n   = !in_span(draw_x, HS_LO, HS_HI, HS_EN);
      raw.vs_n   = !in_span(draw_y, VS_LO, VS_HI, VS_EN);
    end
  end

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(SYNC_IDLE)
  ) u_delay (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .ce     (pix_ce),
    .din    (raw),
    .dout   (dly)
  );

  assign DrawX       = draw_x;
  assign DrawY       = draw_y;
  assign frame_count = frames;
  assign blank       = dly.active;
  assign hs          = dly.hs_n;
  assign vs          = dly.vs_n;
  assign frame_start = reset_n && pix_ce && (draw_x == '0) && (draw_y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // main instance: 640x480@60 defaults
  logic        rst_m, ce_m;
  logic [9:0]  m_x, m_y;
  logic        m_blank, m_hs, m_vs, m_fs;
  logic [15:0] m_fc;

  // small instance: 8x4 raster (x: 4 active, 1 fp, 2 sync, 1 bp; y: 2 active, 0 fp, 1 sync, 1 bp)
  logic        rst_s, ce_s;
  logic [9:0]  s_x, s_y;
  logic        s_blank, s_hs, s_vs, s_fs;
  logic [15:0] s_fc;

  // tiny instance: 1x1 raster, combinational bypass, one frame per tick
  logic        rst_z, ce_z;
  logic [9:0]  z_x, z_y;
  logic        z_blank, z_hs, z_vs, z_fs;
  logic [15:0] z_fc;

  vga_timing_gen u_main (
    .vga_clk(vga_clk), .reset_n(rst_m), .pix_ce(ce_m),
    .DrawX(m_x), .DrawY(m_y), .blank(m_blank), .hs(m_hs), .vs(m_vs),
    .frame_start(m_fs), .frame_count(m_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(0), .V_SYNC(1), .V_BP(1), .PIPE_DLY(2)
  ) u_small (
    .vga_clk(vga_clk), .reset_n(rst_s), .pix_ce(ce_s),
    .DrawX(s_x), .DrawY(s_y), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .PIPE_DLY(0)
  ) u_tiny (
    .vga_clk(vga_clk), .reset_n(rst_z), .pix_ce(ce_z),
    .DrawX(z_x), .DrawY(z_y), .blank(z_blank), .hs(z_hs), .vs(z_vs),
    .frame_start(z_fs), .frame_count(z_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // k is the pixel tick whose raw value is now visible at the delayed outputs
  function automatic logic mdl_hs(int k, int ht, int lo, int n);
    if (k < 0) return 1'b1;
    return !(((k % ht) >= lo) && ((k % ht) < lo + n));
  endfunction

  function automatic logic mdl_vs(int k, int ht, int vt, int lo, int n);
    int y;
    if (k < 0) return 1'b1;
    y = (k / ht) % vt;
    return !((y >= lo) && (y < lo + n));
  endfunction

  function automatic logic mdl_blank(int k, int ht, int vt, int ha, int va);
    if (k < 0) return 1'b0;
    return ((k % ht) < ha) && (((k / ht) % vt) < va);
  endfunction

  initial begin
    int low;
    int fs_cnt, vs_cnt, bl_cnt;

    rst_m = 1'b0; ce_m = 1'b1;
    rst_s = 1'b0; ce_s = 1'b0;
    rst_z = 1'b0; ce_z = 1'b1;
    repeat (3) step();

    check("rst_x", m_x, 0);
    check("rst_y", m_y, 0);
    check("rst_blank", m_blank, 0);
    check("rst_hs", m_hs, 1);
    check("rst_vs", m_vs, 1);
    check("rst_fc", m_fc, 0);
    check("rst_fs", m_fs, 0);
    check("rst_tiny_blank", z_blank, 0);
    check("rst_tiny_fs", z_fs, 0);
    ce_z = 1'b0;

    // one full line with pix_ce held high
    ce_m = 1'b0; rst_m = 1'b1; #1;
    check("fs_ce_low", m_fs, 0);
    ce_m = 1'b1; #1;
    check("fs_first", m_fs, 1);
    check("x_first", m_x, 0);
    low = 0;
    for (int t = 1; t <= 800; t++) begin
      step();
      check($sformatf("lineA_x t=%0d", t), m_x, t % 800);
      check($sformatf("lineA_hs t=%0d", t), m_hs, mdl_hs(t - 2, 800, 656, 96));
      check($sformatf("lineA_blank t=%0d", t), m_blank, mdl_blank(t - 2, 800, 525, 640, 480));
      check($sformatf("lineA_fs t=%0d", t), m_fs, 0);
      if (!m_hs) low++;
    end
    check("lineA_hs_low_cnt", low, 96);
    check("lineA_y_end", m_y, 1);
    check("lineA_vs", m_vs, 1);

    // pix_ce toggling 1,0,1,0
    rst_m = 1'b0; #1; rst_m = 1'b1;
    low = 0;
    begin
      int t;
      t = 0;
      for (int c = 0; c < 1600; c++) begin
        ce_m = (c % 2 == 0);
        step();
        if (ce_m) t++;
        check($sformatf("ceB_x c=%0d", c), m_x, t % 800);
        check($sformatf("ceB_hs c=%0d", c), m_hs, mdl_hs(t - 2, 800, 656, 96));
        check($sformatf("ceB_blank c=%0d", c), m_blank, mdl_blank(t - 2, 800, 525, 640, 480));
        if (!m_hs) low++;
      end
    end
    check("ceB_hs_low_clocks", low, 192);
    ce_m = 1'b0;

    // small raster: frame-level timing
    ce_s = 1'b1; rst_s = 1'b1; #1;
    fs_cnt = s_fs ? 1 : 0;
    vs_cnt = 0;
    bl_cnt = 0;
    check("s_fs_t0", s_fs, 1);
    for (int t = 1; t <= 40; t++) begin
      step();
      check($sformatf("s_x t=%0d", t), s_x, t % 8);
      check($sformatf("s_y t=%0d", t), s_y, (t / 8) % 4);
      check($sformatf("s_hs t=%0d", t), s_hs, mdl_hs(t - 2, 8, 5, 2));
      check($sformatf("s_vs t=%0d", t), s_vs, mdl_vs(t - 2, 8, 4, 2, 1));
      check($sformatf("s_blank t=%0d", t), s_blank, mdl_blank(t - 2, 8, 4, 4, 2));
      check($sformatf("s_fs t=%0d", t), s_fs, (t % 32) == 0);
      check($sformatf("s_fc t=%0d", t), s_fc, t / 32);
      if (t <= 32) begin
        if (s_fs) fs_cnt++;
        if (!s_vs) vs_cnt++;
        if (s_blank) bl_cnt++;
      end
    end
    check("s_fs_pulses", fs_cnt, 2);
    check("s_vs_low_ticks", vs_cnt, 8);
    check("s_blank_ticks", bl_cnt, 8);
    check("s_hs_pre_reset", s_hs, 0);
    check("s_fc_pre_reset", s_fc, 1);

    // asynchronous reset in the middle of an hsync pulse
    rst_s = 1'b0; #2;
    check("s_arst_x", s_x, 0);
    check("s_arst_y", s_y, 0);
    check("s_arst_hs", s_hs, 1);
    check("s_arst_vs", s_vs, 1);
    check("s_arst_blank", s_blank, 0);
    check("s_arst_fc", s_fc, 0);
    check("s_arst_fs", s_fs, 0);
    rst_s = 1'b1; #1;
    check("s_rel_x0", s_x, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("s_rel_x i=%0d", i), s_x, i);
      check($sformatf("s_rel_hs i=%0d", i), s_hs, 1);
    end
    ce_s = 1'b0;

    // frame counter wrap on the 1x1 raster
    rst_z = 1'b1; ce_z = 1'b1; #1;
    check("z_blank_bypass", z_blank, 1);
    check("z_fs", z_fs, 1);
    check("z_hs", z_hs, 1);
    repeat (65535) step();
    check("z_fc_ffff", z_fc, 16'hFFFF);
    check("z_x", z_x, 0);
    step();
    check("z_fc_wrap", z_fc, 0);
    ce_z = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
